// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into 32-bit words with per-lane enables.
// A flush request pushes out a partially filled word; unwritten lanes carry FILL_BYTE.
module byte_packer #(
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        flush,
  output logic [31:0] word_out,
  output logic [3:0]  word_be,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [2:0]  fill_count
);

  logic [31:0] asm_q, asm_d;
  logic [3:0]  asmBe_q, asmBe_d;
  logic [1:0]  idx_q, idx_d;
  logic        flushPend_q, flushPend_d;
  logic [31:0] wordOut_q, wordOut_d;
  logic [3:0]  wordBe_q, wordBe_d;
  logic        wordValid_q, wordValid_d;

  logic        outFree;
  logic        acceptByte;
  logic        flushReq;
  logic        complete;
  logic [31:0] asmMerged;
  logic [3:0]  beMerged;

  // Only the fourth byte has to wait for the output register to free up.
  assign outFree    = !wordValid_q || word_ready;
  assign byte_ready = !rst && ((idx_q != 2'd3) || outFree);
  assign acceptByte = byte_valid && byte_ready;
  assign flushReq   = flush || flushPend_q;

  always_comb begin
    asmMerged = asm_q;
    beMerged  = asmBe_q;
    if (acceptByte) begin
      asmMerged[{idx_q, 3'b000} +: 8] = byte_in;
      beMerged[idx_q]                 = 1'b1;
    end
  end

  // A flush serviced with nothing held and nothing arriving simply retires.
  assign complete = (acceptByte && (idx_q == 2'd3)) ||
                    (flushReq && outFree && ((idx_q != 2'd0) || acceptByte));

  always_comb begin
    asm_d       = asmMerged;
    asmBe_d     = beMerged;
    idx_d       = acceptByte ? idx_q + 2'd1 : idx_q;
    flushPend_d = flushReq && !outFree;
    wordOut_d   = wordOut_q;
    wordBe_d    = wordBe_q;
    wordValid_d = wordValid_q && !word_ready;
    if (complete) begin
      wordOut_d   = asmMerged;
      wordBe_d    = beMerged;
      wordValid_d = 1'b1;
      asm_d       = {4{FILL_BYTE}};
      asmBe_d     = 4'b0000;
      idx_d       = 2'd0;
      flushPend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q       <= {4{FILL_BYTE}};
      asmBe_q     <= 4'b0000;
      idx_q       <= 2'd0;
      flushPend_q <= 1'b0;
      wordOut_q   <= 32'h0;
      wordBe_q    <= 4'b0000;
      wordValid_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      asmBe_q     <= asmBe_d;
      idx_q       <= idx_d;
      flushPend_q <= flushPend_d;
      wordOut_q   <= wordOut_d;
      wordBe_q    <= wordBe_d;
      wordValid_q <= wordValid_d;
    end
  end

  assign word_out   = wordOut_q;
  assign word_be    = wordBe_q;
  assign word_valid = wordValid_q;
  assign fill_count = {1'b0, idx_q};

endmodule

// File: tb/tb_byte_packer.sv
// Bench for byte_packer: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the packing rules.
module tb_byte_packer;

  localparam logic [7:0] FILL = 8'h00;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        flush;
  logic [31:0] word_out;
  logic [3:0]  word_be;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  fill_count;

  byte_packer #(.FILL_BYTE(FILL)) dut (
    .clk       (clk),
    .rst       (rst),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .flush     (flush),
    .word_out  (word_out),
    .word_be   (word_be),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .fill_count(fill_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checkCount = 0;
  int errorCount = 0;

  // Model: bytes waiting to be packed, the pending flush, and the output word.
  logic [7:0]  mBytes[$];
  logic        mFlushPend = 1'b0;
  logic        mValid = 1'b0;
  logic [31:0] mWord = 32'h0;
  logic [3:0]  mBe = 4'h0;
  logic        mAccepted = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelUpdate(input logic r, input logic bv, input logic [7:0] b, input logic fl, input logic wr);
    logic outFree, ready, fr, emit;
    mAccepted = 1'b0;
    if (r) begin
      mBytes.delete();
      mFlushPend = 1'b0;
      mValid = 1'b0;
      mWord = 32'h0;
      mBe = 4'h0;
      return;
    end
    outFree = !mValid || wr;
    ready = (mBytes.size() < 3) || outFree;
    if (bv && ready) begin
      mBytes.push_back(b);
      mAccepted = 1'b1;
    end
    fr = fl || mFlushPend;
    emit = (mBytes.size() == 4) || (fr && outFree && mBytes.size() > 0);
    if (emit) begin
      mWord = 32'h0;
      mBe = 4'h0;
      for (int k = 0; k < 4; k++) begin
        if (k < mBytes.size()) begin
          mWord = mWord | (32'(mBytes[k]) << (8 * k));
          mBe[k] = 1'b1;
        end else begin
          mWord = mWord | (32'(FILL) << (8 * k));
        end
      end
      mValid = 1'b1;
      mBytes.delete();
      mFlushPend = 1'b0;
    end else begin
      if (outFree) mValid = 1'b0;
      mFlushPend = fr && !outFree;
    end
  endtask

  // Drive one cycle of inputs, check outputs at the falling edge, advance the model.
  task automatic applyStimulus(input logic r, input logic bv, input logic [7:0] b, input logic fl, input logic wr);
    logic expReady;
    rst = r;
    byte_valid = bv;
    byte_in = b;
    flush = fl;
    word_ready = wr;
    @(negedge clk);
    expReady = !r && ((mBytes.size() < 3) || !mValid || wr);
    checkOutput("byte_ready", 32'(byte_ready), 32'(expReady));
    checkOutput("word_valid", 32'(word_valid), 32'(mValid));
    checkOutput("fill_count", 32'(fill_count), 32'(mBytes.size()));
    if (mValid) begin
      checkOutput("word_out", word_out, mWord);
      checkOutput("word_be", 32'(word_be), 32'(mBe));
    end
    modelUpdate(r, bv, b, fl, wr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] curByte;
    logic       curValid;
    logic [31:0] firstWord;

    rst = 1'b1;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    flush = 1'b0;
    word_ready = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("reset_valid", 32'(word_valid), 32'd0);
    checkOutput("reset_word", word_out, 32'h0);
    checkOutput("reset_fill", 32'(fill_count), 32'd0);

    // Continuous stream.
    applyStimulus(0, 1, 8'h11, 0, 1);
    applyStimulus(0, 1, 8'h22, 0, 1);
    applyStimulus(0, 1, 8'h33, 0, 1);
    applyStimulus(0, 1, 8'h44, 0, 1);
    checkOutput("cont_word", word_out, 32'h44332211);
    checkOutput("cont_be", 32'(word_be), 32'hF);
    checkOutput("cont_valid", 32'(word_valid), 32'd1);
    applyStimulus(0, 0, 8'h00, 0, 1);
    checkOutput("cont_drop", 32'(word_valid), 32'd0);

    // Backpressure.
    for (int i = 1; i <= 7; i++) applyStimulus(0, 1, 8'(i), 0, 0);
    checkOutput("bp_held_word", word_out, 32'h04030201);
    checkOutput("bp_stall", 32'(byte_ready), 32'd0);
    applyStimulus(0, 1, 8'h08, 0, 0);
    checkOutput("bp_held_again", word_out, 32'h04030201);
    applyStimulus(0, 1, 8'h08, 0, 1);
    checkOutput("bp_second_word", word_out, 32'h08070605);
    applyStimulus(0, 0, 8'h00, 0, 1);

    // Partial flush.
    applyStimulus(0, 1, 8'hAA, 0, 1);
    applyStimulus(0, 1, 8'hBB, 0, 1);
    applyStimulus(0, 0, 8'h00, 1, 1);
    checkOutput("pf_word", word_out, 32'h0000BBAA);
    checkOutput("pf_be", 32'(word_be), 32'h3);
    checkOutput("pf_fill", 32'(fill_count), 32'd0);

    // Flush coincident with a byte, then flush on an empty assembly.
    applyStimulus(0, 1, 8'h01, 0, 1);
    applyStimulus(0, 1, 8'h02, 0, 1);
    applyStimulus(0, 1, 8'hCC, 1, 1);
    checkOutput("cf_word", word_out, 32'h00CC0201);
    checkOutput("cf_be", 32'(word_be), 32'h7);
    applyStimulus(0, 0, 8'h00, 1, 1);
    checkOutput("empty_flush", 32'(word_valid), 32'd0);

    // Flush while the output is blocked.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'h50 + 8'(i), 0, 0);
    applyStimulus(0, 1, 8'h77, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkOutput("pend_held", word_out, 32'h53525150);
    applyStimulus(0, 0, 8'h00, 0, 1);
    checkOutput("pend_word", word_out, 32'h00000077);
    checkOutput("pend_be", 32'(word_be), 32'h1);
    applyStimulus(0, 0, 8'h00, 0, 1);

    // Reset in the middle of assembly with a word waiting.
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 8'h90 + 8'(i), 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("rst_mid_valid", 32'(word_valid), 32'd0);
    checkOutput("rst_mid_word", word_out, 32'h0);
    checkOutput("rst_mid_fill", 32'(fill_count), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'hA0 + 8'(i), 0, 1);
    firstWord = 32'hA3A2A1A0;
    checkOutput("rst_fresh_word", word_out, firstWord);

    // Random traffic; the source holds a byte until it is taken.
    curValid = 1'b0;
    curByte = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      logic r, fl, wr;
      if (!curValid || mAccepted) begin
        curValid = ($urandom_range(0, 3) != 0);
        curByte = 8'($urandom);
      end
      r  = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 7) == 0);
      wr = ($urandom_range(0, 2) != 0);
      applyStimulus(r, curValid, curByte, fl, wr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
Name: byte_packer

Overview:
- Sequential byte-to-word packer for the byte-lane datapath.
- Accepts a stream of bytes over a valid/ready handshake and assembles them little-endian into 32-bit words: first byte goes to [7:0], fourth byte to [31:24].
- Emits each assembled word with per-byte enables over a second valid/ready handshake.
- Supports flushing a partially filled word.

Parameters:
- FILL_BYTE, 8'h00, value driven on byte lanes not written in a flushed partial word.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- byte_in  input  8  incoming byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  packer can accept byte_in this cycle.
- flush  input  1  one-cycle pulse: request emission of the partial word.
- word_out  output  32  assembled word; lane k = bits [8k+7:8k].
- word_be  output  4  lane-valid enables for word_out.
- word_valid  output  1  word_out/word_be are valid.
- word_ready  input  1  downstream consumes the word this cycle.
- fill_count  output  3  bytes currently held in the assembly register (0..3).

Behaviour:
- State:
  - asm_reg[31:0], asm_be[3:0], idx[1:0].
  - Output register: word_out, word_be, word_valid.
  - flush_pending flag.
- Reset (rst=1 at an edge):
  - word_valid=0, word_out=0, word_be=0.
  - asm_reg = {4{FILL_BYTE}}, asm_be=0, idx=0, flush_pending=0.
  - Reset mid-assembly or mid-output discards all held data; no word is emitted.
- byte_ready and its qualifiers:
  - out_free = !word_valid || word_ready.
  - byte_ready = !rst && (idx != 3 || out_free). Combinational.
  - A byte is accepted when byte_valid && byte_ready.
  - byte_ready must not depend on byte_valid.
- Byte accept:
  - Writes byte_in into lane idx of asm_reg and sets asm_be[idx].
  - If idx<3: idx increments.
  - If idx==3: completion event.
- Flush:
  - flush sets flush_pending.
  - Serviced in the first cycle where out_free=1, including the cycle of the pulse itself.
  - At service with idx>0, or with a byte accepted that same cycle: completion event, and the same-cycle byte is included.
  - At service with idx==0 and no byte accepted: flush_pending clears; no word is emitted.
  - flush while already pending has no further effect.
- Completion event (only when out_free=1):
  - Next cycle: word_out = asm_reg including the new byte, with unwritten lanes = FILL_BYTE.
  - Next cycle: word_be = asm_be including the new byte, word_valid=1.
  - asm_reg resets to FILL_BYTE lanes, asm_be=0, idx=0, flush_pending=0.
- Output hold (AXI-stream rules):
  - When word_valid=1 and word_ready=0, word_out/word_be hold stable and word_valid stays 1.
  - When word_ready=1 with no new completion, word_valid drops the next cycle.
  - Completion in the same cycle as word_ready=1 loads the new word back-to-back (word_valid stays 1).
- Timing:
  - Latency: word_valid asserts 1 cycle after the completing accept or flush service.
  - Throughput: 1 byte/cycle sustained with word_ready=1; no bubbles.
- Bytes only at idx 0..2 with output blocked: still accepted (byte_ready=1); only the 4th byte stalls.
- fill_count = idx (registered).
- Bytes on byte_in while byte_ready=0 are not consumed; the source holds them.

Test Plan:
- Continuous: bytes 11,22,33,44 on consecutive cycles, word_ready=1 -> one cycle after the 44 accept, word_out=32'h44332211, word_be=4'hF, word_valid for 1 cycle; byte_ready stays 1 throughout.
- Backpressure: word_ready=0, send 8 bytes 01..08 -> first word 32'h04030201 held stable. 05,06,07 accepted; byte_ready=0 with 08 presented. Raise word_ready -> 08 accepted that cycle, next word 32'h08070605.
- Partial flush: bytes AA,BB then flush pulse (FILL_BYTE=00) -> word_out=32'h0000BBAA, word_be=4'b0011, fill_count returns to 0.
- Flush coincident with byte: 2 bytes held, 3rd byte CC accepted in the same cycle as flush -> word_be=4'b0111, lane2=CC. Flush with empty assembly -> no word_valid.
- Pending flush: output blocked (word_valid=1, word_ready=0), 1 byte held, flush pulse -> no change until word_ready=1. Then the partial word (be=4'b0001) appears 1 cycle after the old word drains.
- Reset mid-operation: rst after 3 bytes with word_valid=1 -> next cycle word_valid=0, word_out=0, fill_count=0. Next 4 bytes form a fresh aligned word.
